// File: rtl/demod_seq_ctrl.sv
// FM demodulation sequencer: pops paired real/imag samples, forms the Q10 conjugate
// product against the previous sample, runs the shared qarctan core and pushes the angle.
module demod_seq_ctrl #(
  parameter int DATA_SIZE = 32,
  parameter int FRAC_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] real_in,
  input  logic                 real_empty,
  output logic                 real_rd_en,
  input  logic [DATA_SIZE-1:0] imag_in,
  input  logic                 imag_empty,
  output logic                 imag_rd_en,
  output logic [DATA_SIZE-1:0] atan_x,
  output logic [DATA_SIZE-1:0] atan_y,
  output logic                 atan_start,
  input  logic                 atan_done,
  input  logic [DATA_SIZE-1:0] atan_result,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_out_wr_en,
  input  logic                 data_out_full
);

  localparam int PW = 2 * DATA_SIZE;
  localparam logic signed [PW:0] ROUND_BIAS = {{(PW + 1 - FRAC_BITS){1'b0}}, {FRAC_BITS{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t                      state_r;
  logic signed [DATA_SIZE-1:0] cur_real_r, cur_imag_r, prev_real_r, prev_imag_r;
  logic signed [PW-1:0]        cr_ext_s, ci_ext_s, pr_ext_s, pi_ext_s;
  logic signed [PW-1:0]        p_rr_s, p_ii_s, p_ir_s, p_ri_s;
  logic signed [PW:0]          re_sum_s, im_sum_s;
  logic [DATA_SIZE-1:0]        re_q_s, im_q_s;
  logic                        pop_s;

  // Bias negative values before the arithmetic shift so the quotient truncates toward zero.
  function automatic logic [DATA_SIZE-1:0] dequant(input logic signed [PW:0] v);
    logic signed [PW:0] bias;
    logic signed [PW:0] q;
    if (v[PW]) bias = ROUND_BIAS;
    else       bias = {(PW + 1){1'b0}};
    q = (v + bias) >>> FRAC_BITS;
    return q[DATA_SIZE-1:0];
  endfunction

  // Conjugate product datapath and the show-ahead FIFO handshakes.
  always_comb begin
    cr_ext_s = {{DATA_SIZE{cur_real_r[DATA_SIZE-1]}},  cur_real_r};
    ci_ext_s = {{DATA_SIZE{cur_imag_r[DATA_SIZE-1]}},  cur_imag_r};
    pr_ext_s = {{DATA_SIZE{prev_real_r[DATA_SIZE-1]}}, prev_real_r};
    pi_ext_s = {{DATA_SIZE{prev_imag_r[DATA_SIZE-1]}}, prev_imag_r};
    p_rr_s   = cr_ext_s * pr_ext_s;
    p_ii_s   = ci_ext_s * pi_ext_s;
    p_ir_s   = ci_ext_s * pr_ext_s;
    p_ri_s   = cr_ext_s * pi_ext_s;
    re_sum_s = {p_rr_s[PW-1], p_rr_s} + {p_ii_s[PW-1], p_ii_s};
    im_sum_s = {p_ir_s[PW-1], p_ir_s} - {p_ri_s[PW-1], p_ri_s};
    re_q_s   = dequant(re_sum_s);
    im_q_s   = dequant(im_sum_s);
    if (!reset && (state_r == S_IDLE) && !real_empty && !imag_empty) pop_s = 1'b1;
    else                                                           pop_s = 1'b0;
    real_rd_en = pop_s;
    imag_rd_en = pop_s;
    if ((state_r == S_WRITE) && !data_out_full) data_out_wr_en = 1'b1;
    else                                        data_out_wr_en = 1'b0;
  end

  // Sequencer FSM; only one sample is ever in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cur_real_r  <= {DATA_SIZE{1'b0}};
      cur_imag_r  <= {DATA_SIZE{1'b0}};
      prev_real_r <= {DATA_SIZE{1'b0}};
      prev_imag_r <= {DATA_SIZE{1'b0}};
      atan_x      <= {DATA_SIZE{1'b0}};
      atan_y      <= {DATA_SIZE{1'b0}};
      atan_start  <= 1'b0;
      data_out    <= {DATA_SIZE{1'b0}};
    end else begin
      atan_start <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            cur_real_r <= real_in;
            cur_imag_r <= imag_in;
            state_r    <= S_MULT;
          end
        end
        S_MULT: begin
          atan_x      <= re_q_s;
          atan_y      <= im_q_s;
          prev_real_r <= cur_real_r;
          prev_imag_r <= cur_imag_r;
          atan_start  <= 1'b1;
          state_r     <= S_START;
        end
        S_START: state_r <= S_WAIT;
        S_WAIT: begin
          if (atan_done) begin
            data_out <= atan_result;
            state_r  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!data_out_full) state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demod_seq_ctrl.sv
// Self-checking bench for demod_seq_ctrl: mock FIFOs, a fixed-latency mock qarctan core and
// an arithmetic reference model of the conjugate product.
module tb_demod_seq_ctrl;

  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] real_in = 32'h0, imag_in = 32'h0, atan_result = 32'h0;
  logic        real_empty = 1'b1, imag_empty = 1'b1, atan_done = 1'b0, data_out_full = 1'b0;
  logic [31:0] atan_x, atan_y, data_out;
  logic        real_rd_en, imag_rd_en, atan_start, data_out_wr_en;

  demod_seq_ctrl #(.DATA_SIZE(32), .FRAC_BITS(10)) dut (
    .clock(clock), .reset(reset),
    .real_in(real_in), .real_empty(real_empty), .real_rd_en(real_rd_en),
    .imag_in(imag_in), .imag_empty(imag_empty), .imag_rd_en(imag_rd_en),
    .atan_x(atan_x), .atan_y(atan_y), .atan_start(atan_start),
    .atan_done(atan_done), .atan_result(atan_result),
    .data_out(data_out), .data_out_wr_en(data_out_wr_en), .data_out_full(data_out_full)
  );

  always #5 clock = ~clock;

  logic [31:0] rq[$], iq[$];
  logic [31:0] exp_x_q[$], exp_y_q[$], exp_w_q[$];
  logic [31:0] sx_log[$], sy_log[$], wr_log[$];
  logic [31:0] prev_r = 32'h0, prev_i = 32'h0;
  int cyc = 0, pops_n = 0, starts_n = 0, writes_n = 0;
  int pop_cyc = 0, start_cyc = 0, wr_cyc = 0;
  int core_cnt = 0, hold_err = 0, order_err = 0, split_err = 0;
  logic [31:0] core_x = 32'h0, core_y = 32'h0;
  bit core_live = 1'b0, inflight = 1'b0;
  int n_checks = 0, n_pass = 0;

  function automatic logic [31:0] core_fn(input logic [31:0] x, input logic [31:0] y);
    return (x ^ {y[30:0], y[31]}) + 32'h0000_1234;
  endfunction

  // Mock FIFOs and qarctan core: drive on the falling edge, sample 1 ns later.
  always @(negedge clock) begin
    cyc++;
    atan_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) atan_done = 1'b1;
    end
    atan_result = core_fn(core_x, core_y);
    real_empty  = (rq.size() == 0);
    imag_empty  = (iq.size() == 0);
    real_in     = real_empty ? 32'h0 : rq[0];
    imag_in     = imag_empty ? 32'h0 : iq[0];
    #1;
    if (reset) begin
      core_live = 1'b0;
      inflight  = 1'b0;
    end
    if (real_rd_en || imag_rd_en) begin
      if (real_rd_en !== imag_rd_en || rq.size() == 0 || iq.size() == 0) split_err++;
      if (inflight) order_err++;
      inflight = 1'b1;
      pops_n++;
      pop_cyc = cyc;
      if (rq.size() > 0) void'(rq.pop_front());
      if (iq.size() > 0) void'(iq.pop_front());
    end
    if (atan_start) begin
      starts_n++;
      start_cyc = cyc;
      core_cnt  = LAT;
      core_x    = atan_x;
      core_y    = atan_y;
      core_live = 1'b1;
      sx_log.push_back(atan_x);
      sy_log.push_back(atan_y);
    end else if (core_cnt > 0 && core_live && (atan_x !== core_x || atan_y !== core_y)) begin
      hold_err++;
    end
    if (data_out_wr_en) begin
      writes_n++;
      wr_cyc   = cyc;
      inflight = 1'b0;
      wr_log.push_back(data_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference: conjugate product at 65 bits, divided by 1024 truncating toward zero.
  task automatic model_sample(input logic [31:0] cr, input logic [31:0] ci);
    logic signed [64:0] a, b, c, d, re, im;
    a  = {{33{cr[31]}}, cr};
    b  = {{33{ci[31]}}, ci};
    c  = {{33{prev_r[31]}}, prev_r};
    d  = {{33{prev_i[31]}}, prev_i};
    re = (a * c + b * d) / 65'sd1024;
    im = (b * c - a * d) / 65'sd1024;
    exp_x_q.push_back(re[31:0]);
    exp_y_q.push_back(im[31:0]);
    exp_w_q.push_back(core_fn(re[31:0], im[31:0]));
    prev_r = cr;
    prev_i = ci;
  endtask

  task automatic push_sample(input logic [31:0] cr, input logic [31:0] ci);
    model_sample(cr, ci);
    rq.push_back(cr);
    iq.push_back(ci);
  endtask

  task automatic wait_writes(input int target, input int budget, input string tag);
    int k = 0;
    while (writes_n < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(writes_n), 32'(target));
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int k = 0;
    while (starts_n < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(starts_n), 32'(target));
  endtask

  task automatic drain(input string tag);
    while (sx_log.size() > 0 && exp_x_q.size() > 0) begin
      chk({tag, "_x"}, sx_log.pop_front(), exp_x_q.pop_front());
      chk({tag, "_y"}, sy_log.pop_front(), exp_y_q.pop_front());
    end
    while (wr_log.size() > 0 && exp_w_q.size() > 0)
      chk({tag, "_w"}, wr_log.pop_front(), exp_w_q.pop_front());
    chk({tag, "_left"}, 32'(sx_log.size() + exp_x_q.size() + wr_log.size() + exp_w_q.size()), 32'd0);
  endtask

  initial begin
    int base, rd_base, pushed;
    logic [31:0] d0;

    // Reset with a sample already waiting: nothing may pop while reset is high.
    push_sample(32'h0000_0400, 32'h0);
    repeat (3) @(negedge clock);
    #2;
    chk("rst_rd_en", {31'h0, real_rd_en}, 32'h0);
    chk("rst_atan_x", atan_x, 32'h0);
    chk("rst_atan_y", atan_y, 32'h0);
    chk("rst_start", {31'h0, atan_start}, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_wr_en", {31'h0, data_out_wr_en}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    wait_writes(1, 40, "s1_writes");
    chk("s1_pops", 32'(pops_n), 32'd1);
    chk("s1_starts", 32'(starts_n), 32'd1);
    chk("s1_x", sx_log[0], 32'h0);
    chk("s1_y", sy_log[0], 32'h0);
    chk("s1_data", wr_log[0], 32'h0000_1234);
    chk("lat_start", 32'(start_cyc - pop_cyc), 32'd2);
    chk("lat_write", 32'(wr_cyc - pop_cyc), 32'(3 + LAT));
    drain("s1");

    push_sample(32'h0, 32'h0000_0400);
    wait_writes(2, 40, "s2_writes");
    chk("s2_x", sx_log[0], 32'h0);
    chk("s2_y", sy_log[0], 32'h0000_0400);
    drain("s2");

    push_sample(32'h1, 32'h0);
    push_sample(32'h0, 32'hFFFF_FFFD);
    push_sample(32'h1, 32'h0);
    push_sample(32'h0, 32'hFFFF_FC00);
    wait_writes(6, 100, "trunc_writes");
    chk("trunc_zero", sy_log[1], 32'h0);
    chk("trunc_m1", sy_log[3], 32'hFFFF_FFFF);
    drain("trunc");

    // Real FIFO alone must never trigger a pop.
    rd_base = pops_n;
    model_sample(32'h1111_2222, 32'hEEEE_DDDD);
    rq.push_back(32'h1111_2222);
    repeat (20) @(negedge clock);
    #2;
    chk("asym_rd_en", {31'h0, real_rd_en}, 32'h0);
    chk("asym_no_pop", 32'(pops_n - rd_base), 32'd0);
    iq.push_back(32'hEEEE_DDDD);
    wait_writes(7, 40, "asym_writes");
    chk("asym_one_pop", 32'(pops_n - rd_base), 32'd1);
    chk("asym_split", 32'(split_err), 32'd0);
    drain("asym");

    // Output backpressure held in S_WRITE; a second sample waits behind it.
    data_out_full = 1'b1;
    base = starts_n;
    push_sample(32'h0123_4567, 32'h89AB_CDEF);
    push_sample(32'hFEDC_BA98, 32'h7654_3210);
    wait_starts(base + 1, 40, "bp_start");
    repeat (LAT + 3) @(negedge clock);
    d0 = data_out;
    repeat (15) @(negedge clock);
    #2;
    chk("bp_wr_en", {31'h0, data_out_wr_en}, 32'h0);
    chk("bp_writes", 32'(writes_n), 32'd7);
    chk("bp_hold", data_out, d0);
    chk("bp_data", data_out, exp_w_q[0]);
    chk("bp_no_pop", 32'(pops_n), 32'd8);
    @(negedge clock);
    data_out_full = 1'b0;
    wait_writes(9, 60, "bp_writes_after");
    chk("bp_order", 32'(order_err), 32'd0);
    drain("bp");

    // Reset while waiting on the core; its late done must be dropped.
    base = starts_n;
    push_sample(32'h0BAD_F00D, 32'h1234_5678);
    wait_starts(base + 1, 40, "abort_start");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_w_q.delete();
    prev_r = 32'h0;
    prev_i = 32'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    #2;
    chk("abort_writes", 32'(writes_n), 32'd9);
    chk("abort_x", atan_x, 32'h0);
    chk("abort_y", atan_y, 32'h0);
    chk("abort_data", data_out, 32'h0);
    chk("abort_start_lo", {31'h0, atan_start}, 32'h0);
    chk("abort_wr_en", {31'h0, data_out_wr_en}, 32'h0);
    drain("abort");

    // Random stream with random output backpressure.
    base   = writes_n;
    pushed = 0;
    for (int k = 0; k < 3000 && writes_n < base + 50; k++) begin
      if (pushed < 50 && $urandom_range(0, 2) == 0) begin
        push_sample($urandom, $urandom);
        pushed++;
      end
      data_out_full = ($urandom_range(0, 3) == 0);
      @(negedge clock);
    end
    data_out_full = 1'b0;
    wait_writes(base + 50, 400, "stream_writes");
    drain("stream");
    chk("stream_hold", 32'(hold_err), 32'd0);
    chk("stream_order", 32'(order_err), 32'd0);
    chk("stream_split", 32'(split_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
